clk_div_bank: RTL and testbench

Multi-channel programmable clock-enable divider with glitch-free runtime reprogramming. It is the parametrised successor of the fixed divide-by-2/4/8/16 counter. Each of CHANNELS channels derives a square wave and a one-cycle tick from `clk` at an independently programmed integer ratio. It sits beside the system clock root and feeds slow-rate enables (display scan, debouncers, LED blink) to downstream logic running on `clk`.

---
 rtl/clk_div_bank.sv | 118 +++++++++++
 tb/tb_clk_div_bank.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of CHANNELS programmable clock-enable dividers.
// Each channel produces a square wave (div_out) and a once-per-period pulse
// (tick) at an integer ratio of clk. Divisors can be rewritten at runtime.
// A write to a running channel is held as pending and applied only at the
// end of the current period, so the outputs never produce a runt pulse.
//
// Optional feature, macro CLKDIV_PHASE_SYNC_EN:
//   defined   - a sync strobe restarts every running channel at cnt=0 and
//               applies any pending divisor, so all ticks line up.
//   undefined - the sync port is present but ignored.
module clk_div_bank #(
  parameter int CHANNELS   = 4,
  parameter int DIV_W      = 8,
  parameter int RESET_POW2 = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                sync,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick
);

  // Per-channel pending flags, gathered so the ready mux can index them.
  logic [CHANNELS-1:0] pend_v;
  logic                cfg_fire;

  // Ready follows the addressed channel's pending flag; out-of-range
  // channel numbers are always ready so their writes are simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == 4'(i)) begin
        cfg_ready = !pend_v[i];
      end
    end
  end

  assign cfg_fire = cfg_valid && cfg_ready;

`ifndef CLKDIV_PHASE_SYNC_EN
  logic unused_sync;
  assign unused_sync = sync;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [DIV_W-1:0] RST_DIV =
      (RESET_POW2 != 0) ? (DIV_W'(2) << g) : '0;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] pend_div_q;
    logic             pend_v_q;
    logic             running;
    logic             at_wrap;
    logic             wr_hit;
    logic             sync_hit;
    logic [DIV_W:0]   high_len;

    assign running  = (div_q != '0);
    assign at_wrap  = running && (cnt_q == (div_q - DIV_W'(1)));
    assign wr_hit   = cfg_fire && (cfg_ch == 4'(g));
    assign pend_v[g] = pend_v_q;

`ifdef CLKDIV_PHASE_SYNC_EN
    // A stopped channel with nothing pending is left alone by sync.
    assign sync_hit = sync && (running || pend_v_q);
`else
    assign sync_hit = 1'b0;
`endif

    // Counter, divisor and pending-write register for one channel.
    // A write can only land while pend_v_q is clear, so the write branch
    // never collides with a pending apply in the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        div_q      <= RST_DIV;
        cnt_q      <= '0;
        pend_div_q <= '0;
        pend_v_q   <= 1'b0;
      end else begin
        if (sync_hit) begin
          cnt_q <= '0;
          if (pend_v_q) begin
            div_q    <= pend_div_q;
            pend_v_q <= 1'b0;
          end
        end else if (pend_v_q && at_wrap) begin
          div_q    <= pend_div_q;
          cnt_q    <= '0;
          pend_v_q <= 1'b0;
        end else if (running) begin
          cnt_q <= at_wrap ? '0 : cnt_q + DIV_W'(1);
        end

        if (wr_hit) begin
          if (!running) begin
            // Nothing to finish on a stopped channel: start immediately.
            div_q <= cfg_div;
            cnt_q <= '0;
          end else begin
            pend_div_q <= cfg_div;
            pend_v_q   <= 1'b1;
          end
        end
      end
    end

    // High phase is ceil(div/2); one extra bit keeps div=max from wrapping.
    assign high_len   = ({1'b0, div_q} + (DIV_W + 1)'(1)) >> 1;
    assign div_out[g] = running && ({1'b0, cnt_q} < high_len);
    assign tick[g]    = running && (cnt_q == '0);
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (CHANNELS=4, DIV_W=8, RESET_POW2=1).
// Expectations for the sync test depend on CLKDIV_PHASE_SYNC_EN.
module tb_clk_div_bank;
  localparam int CH = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [3:0]    cfg_ch = 4'd0;
  logic [DW-1:0] cfg_div = '0;
  logic          sync = 1'b0;
  logic [CH-1:0] div_out;
  logic [CH-1:0] tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_div_bank #(.CHANNELS(CH), .DIV_W(DW), .RESET_POW2(1)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sync(sync),
    .div_out(div_out), .tick(tick)
  );

  typedef struct {
    logic [3:0] ch;     // probe channel driven on cfg_ch (cfg_valid low)
    logic [3:0] tick;   // expected tick[3:0]
    logic [3:0] dout;   // expected div_out[3:0]
    logic       ready;  // expected cfg_ready
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    sync = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Holds the request until ready, then steps through the accepting edge.
  task automatic do_write(input logic [3:0] ch, input logic [DW-1:0] d, output int waited);
    cfg_ch = ch;
    cfg_div = d;
    cfg_valid = 1'b1;
    waited = 0;
    #1;
    while (!cfg_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!cfg_ready) begin
      chk("write_timeout", 32'(waited), 32'd0);
    end
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [9:0] tp;
    logic [9:0] op;

    // Power-of-two reset pattern, cycle k after reset (ch3..ch0 bits).
    tbl[0]  = '{4'd0, 4'b1111, 4'b1111, 1'b1};
    tbl[1]  = '{4'd1, 4'b0000, 4'b1110, 1'b1};
    tbl[2]  = '{4'd2, 4'b0001, 4'b1101, 1'b1};
    tbl[3]  = '{4'd3, 4'b0000, 4'b1100, 1'b1};
    tbl[4]  = '{4'd4, 4'b0011, 4'b1011, 1'b1};
    tbl[5]  = '{4'd5, 4'b0000, 4'b1010, 1'b1};
    tbl[6]  = '{4'd6, 4'b0001, 4'b1001, 1'b1};
    tbl[7]  = '{4'd7, 4'b0000, 4'b1000, 1'b1};
    tbl[8]  = '{4'd15, 4'b0111, 4'b0111, 1'b1};
    tbl[9]  = '{4'd0, 4'b0000, 4'b0110, 1'b1};
    tbl[10] = '{4'd1, 4'b0001, 4'b0101, 1'b1};
    tbl[11] = '{4'd2, 4'b0000, 4'b0100, 1'b1};
    tbl[12] = '{4'd3, 4'b0011, 4'b0011, 1'b1};
    tbl[13] = '{4'd9, 4'b0000, 4'b0010, 1'b1};
    tbl[14] = '{4'd1, 4'b0001, 4'b0001, 1'b1};
    tbl[15] = '{4'd2, 4'b0000, 4'b0000, 1'b1};

    // Reset cycle itself already decodes reset values.
    rst = 1'b1;
    step();
    step();
    chk("rst_cycle_tick", 32'(tick), 32'hF);
    chk("rst_cycle_dout", 32'(div_out), 32'hF);
    rst = 1'b0;

    // 32 cycles of free-running 2/4/8/16.
    for (int k = 0; k < 32; k++) begin
      if (k > 0) step();
      cfg_ch = tbl[k % 16].ch;
      #1;
      chk($sformatf("pow2_tick_k%0d", k), 32'(tick), 32'(tbl[k % 16].tick));
      chk($sformatf("pow2_dout_k%0d", k), 32'(div_out), 32'(tbl[k % 16].dout));
      chk($sformatf("pow2_ready_k%0d", k), 32'(cfg_ready), 32'(tbl[k % 16].ready));
    end

    // Out-of-range channel write: accepted at once, no effect.
    do_reset();
    do_write(4'd5, 8'd7, w);
    chk("oor_wait", 32'(w), 32'd0);
    cfg_ch = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (k > 1) step();
      chk($sformatf("oor_tick_k%0d", k), 32'(tick), 32'(tbl[k].tick));
      chk($sformatf("oor_dout_k%0d", k), 32'(div_out), 32'(tbl[k].dout));
    end

    // Stop channel 1 (running div=4, written at cnt=0), then write div=5.
    do_reset();
    do_write(4'd1, 8'd0, w);
    chk("b_ready_pend", 32'(cfg_ready), 32'd0);
    step();
    step();
    step();
    chk("b_stopped", 32'({cfg_ready, tick[1], div_out[1]}), 32'b100);
    step();
    chk("b_stopped_hold", 32'({tick[1], div_out[1]}), 32'b00);
    do_write(4'd1, 8'd5, w);
    chk("b_wait", 32'(w), 32'd0);
    tp = 10'b0000100001;
    op = 10'b0011100111;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) step();
      chk($sformatf("b_div5_tick_j%0d", j), 32'(tick[1]), 32'(tp[j]));
      chk($sformatf("b_div5_dout_j%0d", j), 32'(div_out[1]), 32'(op[j]));
    end

    // Channel 0: 2 -> 8, then write 3 while cnt=2.
    do_reset();
    do_write(4'd0, 8'd8, w);
    chk("c_ready_pend8", 32'(cfg_ready), 32'd0);
    step();
    chk("c_div8_start", 32'({cfg_ready, tick[0]}), 32'b11);
    step();
    step();
    do_write(4'd0, 8'd3, w);
    chk("c_wait", 32'(w), 32'd0);
    chk("c_after_accept", 32'({cfg_ready, tick[0], div_out[0]}), 32'b001);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("c_old_tail_%0d", j), 32'({cfg_ready, tick[0], div_out[0]}), 32'b000);
    end
    step();
    chk("c_div3_p0", 32'({cfg_ready, tick[0], div_out[0]}), 32'b111);
    step();
    chk("c_div3_p1", 32'({cfg_ready, tick[0], div_out[0]}), 32'b101);
    step();
    chk("c_div3_p2", 32'({cfg_ready, tick[0], div_out[0]}), 32'b100);
    step();
    chk("c_div3_p3", 32'({cfg_ready, tick[0], div_out[0]}), 32'b111);

    // Second write while pending stalls until the apply edge.
    do_write(4'd0, 8'd6, w);
    do_write(4'd0, 8'd2, w);
    chk("d_stall_cycles", 32'(w), 32'd2);
    chk("d_after_accept", 32'({cfg_ready, tick[0], div_out[0]}), 32'b001);
    step();
    chk("d_div6_cnt2", 32'(div_out[0]), 32'd1);
    step();
    chk("d_div6_cnt3", 32'(div_out[0]), 32'd0);
    step();
    step();
    chk("d_div6_end", 32'({cfg_ready, tick[0], div_out[0]}), 32'b000);
    step();
    chk("d_div2_p0", 32'({cfg_ready, tick[0], div_out[0]}), 32'b111);
    step();
    chk("d_div2_p1", 32'({cfg_ready, tick[0], div_out[0]}), 32'b100);
    step();
    chk("d_div2_p2", 32'({cfg_ready, tick[0], div_out[0]}), 32'b111);

    // Stop running channel 2 (div=8), then div=1.
    do_reset();
    do_write(4'd2, 8'd0, w);
    chk("e_cnt1", 32'({tick[2], div_out[2]}), 32'b01);
    repeat (6) step();
    chk("e_cnt7", 32'({cfg_ready, tick[2], div_out[2]}), 32'b000);
    step();
    chk("e_stopped", 32'({cfg_ready, tick[2], div_out[2]}), 32'b100);
    step();
    chk("e_stopped_hold", 32'({tick[2], div_out[2]}), 32'b00);
    do_write(4'd2, 8'd1, w);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) step();
      chk($sformatf("e_div1_%0d", j), 32'({tick[2], div_out[2]}), 32'b11);
    end

    // Reset discards a pending write.
    do_reset();
    do_write(4'd2, 8'd0, w);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg_ch = 4'd2;
    #1;
    chk("r_ready", 32'(cfg_ready), 32'd1);
    chk("r_tick", 32'(tick), 32'hF);
    repeat (8) step();
    chk("r_ch2_still_div8", 32'(tick[2]), 32'd1);

    // Phase sync with divisors 3/4/7.
    do_reset();
    do_write(4'd0, 8'd0, w);
    do_write(4'd1, 8'd0, w);
    do_write(4'd2, 8'd0, w);
    do_write(4'd3, 8'd0, w);
    repeat (20) step();
    chk("s_all_stopped", 32'({tick, div_out}), 32'h00);
    do_write(4'd0, 8'd3, w);
    do_write(4'd1, 8'd4, w);
    do_write(4'd2, 8'd7, w);
    step();
    step();
    chk("s_pre_sync", 32'(tick[2:0]), 32'b000);
    sync = 1'b1;
    step();
    sync = 1'b0;
`ifdef CLKDIV_PHASE_SYNC_EN
    chk("s_sync_ticks", 32'(tick[2:0]), 32'b111);
    step();
    chk("s_sync_next", 32'(tick[2:0]), 32'b000);
`else
    chk("s_sync_ticks", 32'(tick[2:0]), 32'b010);
    step();
    chk("s_sync_next", 32'(tick[2:0]), 32'b001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
